// File: rtl/czono_op_sequencer.sv
`default_nettype none
// czono_op_sequencer -- dimension-checked command sequencer for the PLUS/IMAGE/INTERSECT units (rev 1.0)
// Optional watchdog on the WAIT state: define CZONO_SEQ_TIMEOUT_EN.
module czono_op_sequencer #(
    parameter int NMAX        = 10,
    parameter int NGMAX       = 5,
    parameter int NCMAX       = 3,
    parameter int NRMAX       = 10,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [7:0]       z_n_i,
    input  logic [7:0]       z_ng_i,
    input  logic [7:0]       z_nc_i,
    input  logic [7:0]       w_n_i,
    input  logic [7:0]       w_ng_i,
    input  logic [7:0]       w_nc_i,
    input  logic [7:0]       r_n_i,
    input  logic [7:0]       r_nr_i,
    output logic             plus_start_o,
    output logic             image_start_o,
    output logic             isect_start_o,
    input  logic             plus_done_i,
    input  logic             image_done_i,
    input  logic             isect_done_i,
    output logic             abort_o,
    output logic             busy_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_status_o,
    output logic [1:0]       rsp_op_o,
    output logic [CNT_W-1:0] rsp_cycles_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] OP_PLUS  = 2'd0;
    localparam logic [1:0] OP_IMAGE = 2'd1;
    localparam logic [1:0] OP_ISECT = 2'd2;
    localparam logic [1:0] OP_BAD   = 2'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_DIM_ERR = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BAD_OP  = 2'd3;

    localparam logic [9:0]       C_NMAX    = 10'(NMAX);
    localparam logic [9:0]       C_NGMAX   = 10'(NGMAX);
    localparam logic [9:0]       C_NCMAX   = 10'(NCMAX);
    localparam logic [9:0]       C_NRMAX   = 10'(NRMAX);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       zn_q, zng_q, znc_q, wn_q, wng_q, wnc_q, rn_q, rnr_q;
    logic [7:0]       zn_d, zng_d, znc_d, wn_d, wng_d, wnc_d, rn_d, rnr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [1:0]       rsp_op_q, rsp_op_d;
    logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;

    // Dimensions widened to 10 bits so the sums of up to three 8-bit values cannot wrap
    logic [9:0] w_zn, w_zng, w_znc, w_wn, w_wng, w_wnc, w_rn, w_rnr;
    logic [9:0] w_sum_ng, w_sum_nc, w_sum_nc3;
    logic       w_plus_ok, w_image_ok, w_isect_ok, w_dims_ok;
    logic       w_done_sel;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_zn  = {2'b00, zn_q};
    assign w_zng = {2'b00, zng_q};
    assign w_znc = {2'b00, znc_q};
    assign w_wn  = {2'b00, wn_q};
    assign w_wng = {2'b00, wng_q};
    assign w_wnc = {2'b00, wnc_q};
    assign w_rn  = {2'b00, rn_q};
    assign w_rnr = {2'b00, rnr_q};

    assign w_sum_ng  = w_zng + w_wng;
    assign w_sum_nc  = w_znc + w_wnc;
    assign w_sum_nc3 = w_sum_nc + w_rnr;

    assign w_plus_ok  = (w_zn == w_wn) && (w_zn >= 10'd1) && (w_zn <= C_NMAX) &&
                        (w_sum_ng <= C_NGMAX) && (w_sum_nc <= C_NCMAX);
    assign w_image_ok = (w_rn == w_zn) && (w_zn >= 10'd1) && (w_zn <= C_NMAX) &&
                        (w_rnr >= 10'd1) && (w_rnr <= C_NRMAX) && (w_zng <= C_NGMAX);
    assign w_isect_ok = (w_rn == w_zn) && (w_rnr == w_wn) &&
                        (w_sum_ng <= C_NGMAX) && (w_sum_nc3 <= C_NCMAX);

    always_comb begin
        w_dims_ok  = 1'b0;
        w_done_sel = 1'b0;
        case (op_q)
            OP_PLUS:  begin w_dims_ok = w_plus_ok;  w_done_sel = plus_done_i;  end
            OP_IMAGE: begin w_dims_ok = w_image_ok; w_done_sel = image_done_i; end
            OP_ISECT: begin w_dims_ok = w_isect_ok; w_done_sel = isect_done_i; end
            default:  begin w_dims_ok = 1'b0;       w_done_sel = 1'b0;         end
        endcase
    end

    assign w_cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef CZONO_SEQ_TIMEOUT_EN
    logic abort_q, abort_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^C_TIMEOUT;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        zn_d         = zn_q;
        zng_d        = zng_q;
        znc_d        = znc_q;
        wn_d         = wn_q;
        wng_d        = wng_q;
        wnc_d        = wnc_q;
        rn_d         = rn_q;
        rnr_d        = rnr_q;
        cnt_d        = cnt_q;
        rsp_status_d = rsp_status_q;
        rsp_op_d     = rsp_op_q;
        rsp_cycles_d = rsp_cycles_q;
`ifdef CZONO_SEQ_TIMEOUT_EN
        abort_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    zn_d    = z_n_i;
                    zng_d   = z_ng_i;
                    znc_d   = z_nc_i;
                    wn_d    = w_n_i;
                    wng_d   = w_ng_i;
                    wnc_d   = w_nc_i;
                    rn_d    = r_n_i;
                    rnr_d   = r_nr_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (op_q == OP_BAD || !w_dims_ok) begin
                    rsp_status_d = (op_q == OP_BAD) ? ST_BAD_OP : ST_DIM_ERR;
                    rsp_op_d     = op_q;
                    rsp_cycles_d = '0;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = w_cnt_inc;
                // Done is checked before the watchdog so a same-cycle done still reports OK
                if (w_done_sel) begin
                    rsp_status_d = ST_OK;
                    rsp_op_d     = op_q;
                    rsp_cycles_d = w_cnt_inc;
                    state_d      = S_RESP;
                end
`ifdef CZONO_SEQ_TIMEOUT_EN
                else if (w_cnt_inc == C_TIMEOUT) begin
                    abort_d      = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_op_d     = op_q;
                    rsp_cycles_d = w_cnt_inc;
                    state_d      = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            zn_q         <= '0;
            zng_q        <= '0;
            znc_q        <= '0;
            wn_q         <= '0;
            wng_q        <= '0;
            wnc_q        <= '0;
            rn_q         <= '0;
            rnr_q        <= '0;
            cnt_q        <= '0;
            rsp_status_q <= '0;
            rsp_op_q     <= '0;
            rsp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            zn_q         <= zn_d;
            zng_q        <= zng_d;
            znc_q        <= znc_d;
            wn_q         <= wn_d;
            wng_q        <= wng_d;
            wnc_q        <= wnc_d;
            rn_q         <= rn_d;
            rnr_q        <= rnr_d;
            cnt_q        <= cnt_d;
            rsp_status_q <= rsp_status_d;
            rsp_op_q     <= rsp_op_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

`ifdef CZONO_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
        end
    end
    assign abort_o = abort_q;
`else
    assign abort_o = 1'b0;
`endif

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rsp_valid_o   = (state_q == S_RESP);
    assign plus_start_o  = (state_q == S_ISSUE) && (op_q == OP_PLUS);
    assign image_start_o = (state_q == S_ISSUE) && (op_q == OP_IMAGE);
    assign isect_start_o = (state_q == S_ISSUE) && (op_q == OP_ISECT);
    assign rsp_status_o  = rsp_status_q;
    assign rsp_op_o      = rsp_op_q;
    assign rsp_cycles_o  = rsp_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_czono_op_sequencer.sv
`default_nettype none
// tb_czono_op_sequencer -- directed self-checking bench for czono_op_sequencer (rev 1.0)
// Watchdog vectors are compiled in when CZONO_SEQ_TIMEOUT_EN is defined.
module tb_czono_op_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [7:0]       z_n = '0, z_ng = '0, z_nc = '0;
    logic [7:0]       w_n = '0, w_ng = '0, w_nc = '0;
    logic [7:0]       r_n = '0, r_nr = '0;
    logic             plus_start, image_start, isect_start;
    logic             plus_done = 1'b0, image_done = 1'b0, isect_done = 1'b0;
    logic             abort;
    logic             busy;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_status;
    logic [1:0]       rsp_op;
    logic [CNT_W-1:0] rsp_cycles;

    int n_pass  = 0;
    int n_total = 0;
    int n_pstart = 0, n_istart = 0, n_xstart = 0, n_abort = 0;

    czono_op_sequencer #(
        .NMAX(10), .NGMAX(5), .NCMAX(3), .NRMAX(10), .TIMEOUT_CYC(8), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .z_n_i(z_n), .z_ng_i(z_ng), .z_nc_i(z_nc),
        .w_n_i(w_n), .w_ng_i(w_ng), .w_nc_i(w_nc),
        .r_n_i(r_n), .r_nr_i(r_nr),
        .plus_start_o(plus_start), .image_start_o(image_start), .isect_start_o(isect_start),
        .plus_done_i(plus_done), .image_done_i(image_done), .isect_done_i(isect_done),
        .abort_o(abort), .busy_o(busy),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_status_o(rsp_status), .rsp_op_o(rsp_op), .rsp_cycles_o(rsp_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (plus_start)  n_pstart++;
        if (image_start) n_istart++;
        if (isect_start) n_xstart++;
        if (abort)       n_abort++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int starts_of(input logic [1:0] op);
        case (op)
            2'd0:    return n_pstart;
            2'd1:    return n_istart;
            2'd2:    return n_xstart;
            default: return n_pstart + n_istart + n_xstart;
        endcase
    endfunction

    task automatic set_done(input logic [1:0] op, input logic v);
        case (op)
            2'd0:    plus_done  = v;
            2'd1:    image_done = v;
            2'd2:    isect_done = v;
            default: ;
        endcase
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [7:0] zn, zng, znc, wn, wng, wnc, rn, rnr);
        cmd_op = op;
        z_n = zn; z_ng = zng; z_nc = znc;
        w_n = wn; w_ng = wng; w_nc = wnc;
        r_n = rn; r_nr = rnr;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] zn, zng, znc, wn, wng, wnc, rn, rnr);
        set_cmd(op, zn, zng, znc, wn, wng, wnc, rn, rnr);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        for (int k = 0; k < 40 && !rsp_valid; k++) tick;
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    // done_after > 0: done pulsed in that WAIT cycle; 0: error path; -1: no done at all
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [7:0] zn, zng, znc, wn, wng, wnc, rn, rnr,
                          input int done_after, input logic [1:0] exp_st, input int exp_cyc,
                          input int exp_starts, input int exp_aborts);
        int s0, a0;
        s0 = starts_of(op);
        a0 = n_abort;
        send_cmd(op, zn, zng, znc, wn, wng, wnc, rn, rnr);
        tick;
        if (done_after > 0) begin
            for (int k = 0; k < done_after; k++) tick;
            set_done(op, 1'b1);
            tick;
            set_done(op, 1'b0);
        end
        wait_resp(tag);
        check_eq({tag, "_status"}, 32'(rsp_status), 32'(exp_st));
        check_eq({tag, "_op"}, 32'(rsp_op), 32'(op));
        check_eq({tag, "_cycles"}, 32'(rsp_cycles), 32'(exp_cyc));
        check_eq({tag, "_starts"}, 32'(starts_of(op) - s0), 32'(exp_starts));
        check_eq({tag, "_aborts"}, 32'(n_abort - a0), 32'(exp_aborts));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_eq({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int s0;
        tick; tick;
        rst = 1'b0;
        tick;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_abort", 32'(abort), 32'd0);
        check_eq("rst_starts", 32'({plus_start, image_start, isect_start}), 32'd0);
        check_eq("rst_rsp_fields", 32'({rsp_status, rsp_op, rsp_cycles}), 32'd0);

        // PLUS Z(2,3,1)+W(2,2,1), done 4 cycles after start, foreign dones ignored
        s0 = n_pstart;
        send_cmd(2'd0, 8'd2, 8'd3, 8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0);
        check_eq("plus_check_busy", 32'(busy), 32'd1);
        check_eq("plus_check_ready", 32'(cmd_ready), 32'd0);
        tick;
        check_eq("plus_issue_start", 32'({plus_start, image_start, isect_start}), 32'b100);
        tick; tick;
        image_done = 1'b1; isect_done = 1'b1;
        tick;
        image_done = 1'b0; isect_done = 1'b0;
        check_eq("plus_foreign_done_ignored", 32'(rsp_valid), 32'd0);
        check_eq("plus_still_busy", 32'(busy), 32'd1);
        tick;
        plus_done = 1'b1;
        tick;
        plus_done = 1'b0;
        check_eq("plus_valid", 32'(rsp_valid), 32'd1);
        check_eq("plus_status", 32'(rsp_status), 32'd0);
        check_eq("plus_op", 32'(rsp_op), 32'd0);
        check_eq("plus_cycles", 32'(rsp_cycles), 32'd4);
        check_eq("plus_one_start", 32'(n_pstart - s0), 32'd1);

        // Hold the response for 5 cycles with an INTERSECT command already waiting
        set_cmd(2'd2, 8'd2, 8'd3, 8'd1, 8'd2, 8'd2, 8'd1, 8'd2, 8'd2);
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_fields", 32'({rsp_status, rsp_op, rsp_cycles}), 32'({2'd0, 2'd0, 16'd4}));
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check_eq("after_hs_idle", 32'(cmd_ready), 32'd1);
        check_eq("after_hs_valid", 32'(rsp_valid), 32'd0);

        // INTERSECT with 1+1+2=4 constraints > NCMAX=3
        s0 = n_xstart;
        tick;
        cmd_valid = 1'b0;
        tick;
        check_eq("isect_dim_valid", 32'(rsp_valid), 32'd1);
        check_eq("isect_dim_status", 32'(rsp_status), 32'd1);
        check_eq("isect_dim_op", 32'(rsp_op), 32'd2);
        check_eq("isect_dim_cycles", 32'(rsp_cycles), 32'd0);
        check_eq("isect_dim_no_start", 32'(n_xstart - s0), 32'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        run_op("bad_op",     2'd3, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd2, 0, 2'd3, 0, 0, 0);
        run_op("image_1cyc", 2'd1, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 1, 2'd0, 1, 1, 0);
        run_op("image_nr0",  2'd1, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 0, 2'd1, 0, 0, 0);
        run_op("image_zn0",  2'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 0, 2'd1, 0, 0, 0);
        run_op("plus_edge",  2'd0, 8'd10, 8'd3, 8'd2, 8'd10, 8'd2, 8'd1, 8'd0, 8'd0, 2, 2'd0, 2, 1, 0);
        run_op("plus_n11",   2'd0, 8'd11, 8'd1, 8'd0, 8'd11, 8'd1, 8'd0, 8'd0, 8'd0, 0, 2'd1, 0, 0, 0);
        run_op("plus_ng6",   2'd0, 8'd2, 8'd3, 8'd0, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 0, 2'd1, 0, 0, 0);
        run_op("plus_wrap",  2'd0, 8'd2, 8'd255, 8'd0, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 0, 2'd1, 0, 0, 0);
        run_op("isect_ok",   2'd2, 8'd2, 8'd2, 8'd1, 8'd2, 8'd2, 8'd0, 8'd2, 8'd2, 3, 2'd0, 3, 1, 0);
`ifdef CZONO_SEQ_TIMEOUT_EN
        run_op("timeout",    2'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, -1, 2'd2, 8, 1, 1);
        run_op("done_at_to", 2'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8, 2'd0, 8, 1, 0);
`else
        run_op("long_wait",  2'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 12, 2'd0, 12, 1, 0);
`endif

        // Reset while waiting: operation dropped, no response, no abort
        s0 = n_abort;
        send_cmd(2'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0);
        tick; tick; tick;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("wait_rst_busy", 32'(busy), 32'd0);
        check_eq("wait_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("wait_rst_fields", 32'({rsp_status, rsp_op, rsp_cycles}), 32'd0);
        for (int k = 0; k < 12; k++) tick;
        check_eq("wait_rst_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("wait_rst_no_abort", 32'(n_abort - s0), 32'd0);
        run_op("post_rst",   2'd1, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd10, 5, 2'd0, 5, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
